// File: rtl/rlc_game_pio_in_debounced_pkg.sv
// Shared definitions for the RLC game PIO family (input port today,
// bidirectional port later): register addresses and edge-capture encodings.
package rlc_game_pio_pkg;

  // Register map of the 2-bit Avalon-MM slave
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Which debounced transition sets an edge-capture bit
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Per-bit edge selection used by every PIO that has an edge-capture register
  function automatic logic [31:0] edge_select(input int edge_type,
                                              input logic [31:0] rise,
                                              input logic [31:0] fall);
    if (edge_type == int'(EDGE_RISE))      edge_select = rise;
    else if (edge_type == int'(EDGE_FALL)) edge_select = fall;
    else                                   edge_select = rise | fall;
  endfunction

endpackage

// File: rtl/rlc_game_pio_in_debounced_if.sv
// Avalon-MM register slave bus of the RLC game input PIO, plus its interrupt.
interface rlc_game_pio_in_debounced_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  // Nios II side
  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  // PIO side
  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/rlc_game_pio_in_debounced_debounce_bit.sv
// One input bit: two-flop synchroniser, hold-time debounce counter, the
// accepted (stable) level and its one-cycle delayed copy for edge detection.
module rlc_game_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic stable_d
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] count;

  // Two-stage synchroniser for the asynchronous board input
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // with = the second stage would see the new first stage in the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_LEVEL;
      sync <= RESET_LEVEL;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES clocks;
  // any return to the stable level restarts the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      stable <= RESET_LEVEL;
    end else if (sync == stable) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      stable <= sync;
      count  <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Delayed copy of the accepted level for the edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable_d <= RESET_LEVEL;
    else          stable_d <= stable;
  end

endmodule

// File: rtl/rlc_game_pio_in_debounced.sv
// RLC game debounced input PIO: Avalon-MM slave with data, irqmask and a
// sticky edge-capture register driving a level interrupt.
// Build option RLC_GAME_PIO_IN_BITCLEAR_EN: writes to the edge-capture
// register clear only the bits set in writedata (default: clear all).
module rlc_game_pio_in_debounced
  import rlc_game_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [WIDTH-1:0]            in_port,
  rlc_game_pio_in_debounced_if.slave  bus
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [31:0]      readdata;
  logic             wr;

  for (genvar n = 0; n < WIDTH; n++) begin : g_bit
    rlc_game_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw      (in_port[n]),
      .stable   (stable[n]),
      .stable_d (stable_d[n])
    );
  end

  // Upper write-data bits carry no register state in narrow builds
  if (WIDTH < 32) begin : g_unused_hi
    wire unused_writedata_hi = ^bus.writedata[31:WIDTH];
  end

  assign wr   = bus.chipselect & ~bus.write_n;
  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  assign edge_hit = WIDTH'(edge_select(EDGE_TYPE, 32'(rise), 32'(fall)));

`ifdef RLC_GAME_PIO_IN_BITCLEAR_EN
  assign clr = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
`else
  assign clr = (wr && bus.address == ADDR_EDGECAP) ? '1 : '0;
`endif

  // irqmask write and sticky edge capture; a new edge beats a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr && bus.address == ADDR_IRQMASK) irqmask <= bus.writedata[WIDTH-1:0];
      edgecap <= (edgecap & ~clr) | edge_hit;
    end
  end

  // Zero-wait-state read mux; reads have no side effects
  // NOTE: readdata gets a default first so no address leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    readdata = '0;
    case (bus.address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      default:      readdata = '0;
    endcase
  end

  assign bus.readdata = readdata;
  assign bus.irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_rlc_game_pio_in_debounced.sv
// Self-checking bench for rlc_game_pio_in_debounced with WIDTH=4,
// DEBOUNCE_CYCLES=4, falling-edge capture and idle-high inputs.
module tb_rlc_game_pio_in_debounced;
  import rlc_game_pio_pkg::*;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_port = 4'hF;

  rlc_game_pio_in_debounced_if bus_if ();

  rlc_game_pio_in_debounced #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DB),
    .EDGE_TYPE       (1),
    .RESET_LEVEL     (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Push the expected register value, present the address, then compare
  task automatic expect_reg(input string tag, input logic [1:0] addr, input logic [31:0] value);
    exp_t e;
    exp_q.push_back('{tag: tag, value: value});
    bus_if.address = addr;
    #1;
    e = exp_q.pop_front();
    check(e.tag, bus_if.readdata, e.value);
  endtask

  task automatic expect_irq(input string tag, input logic value);
    exp_t e;
    exp_q.push_back('{tag: tag, value: 32'(value)});
    #1;
    e = exp_q.pop_front();
    check(e.tag, 32'(bus_if.irq), e.value);
  endtask

  // Drive a write at a negedge; it commits on the following posedge
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  initial begin
    bus_if.address    = ADDR_DATA;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;

    // 1. Reset state, held and after release with idle-high keys
    idle(2);
    expect_reg("rst_in_data", ADDR_DATA, 32'hF);
    expect_reg("rst_in_ecap", ADDR_EDGECAP, 32'h0);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      expect_reg("rst_data", ADDR_DATA, 32'hF);
      expect_reg("rst_mask", ADDR_IRQMASK, 32'h0);
      expect_reg("rst_ecap", ADDR_EDGECAP, 32'h0);
      expect_irq("rst_irq", 1'b0);
    end

    // 2. Press key 0: stable at edge k+5, captured and irq at edge k+6
    bus_write(ADDR_IRQMASK, 32'h1);
    in_port = 4'hE;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      expect_reg("press_data", ADDR_DATA, (e >= DB + 1) ? 32'hE : 32'hF);
      expect_reg("press_ecap", ADDR_EDGECAP, (e >= DB + 2) ? 32'h1 : 32'h0);
      expect_irq("press_irq", e >= DB + 2);
    end
    in_port = 4'hF;
    idle(8);
    expect_reg("release_data", ADDR_DATA, 32'hF);
    expect_reg("release_ecap_held", ADDR_EDGECAP, 32'h1);
    bus_write(ADDR_EDGECAP, 32'hF);
    expect_reg("clear_ecap", ADDR_EDGECAP, 32'h0);
    expect_irq("clear_irq", 1'b0);

    // 3. Glitch of DEBOUNCE_CYCLES-1 clocks on key 1 is rejected
    in_port = 4'hD;
    idle(DB - 1);
    in_port = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      expect_reg("glitch_data", ADDR_DATA, 32'hF);
      expect_reg("glitch_ecap", ADDR_EDGECAP, 32'h0);
      expect_irq("glitch_irq", 1'b0);
    end
    expect_reg("dir_reads_zero", ADDR_DIR, 32'h0);

    // 4. Masked capture on key 2, then unmask and clear
    bus_write(ADDR_IRQMASK, 32'h0);
    in_port = 4'hB;
    idle(8);
    expect_reg("mask_ecap", ADDR_EDGECAP, 32'h4);
    expect_irq("masked_irq", 1'b0);
    bus_write(ADDR_IRQMASK, 32'h4);
    expect_reg("mask_readback", ADDR_IRQMASK, 32'h4);
    expect_irq("unmasked_irq", 1'b1);
    bus_write(ADDR_EDGECAP, 32'h0);
`ifdef RLC_GAME_PIO_IN_BITCLEAR_EN
    expect_reg("clr0_ecap", ADDR_EDGECAP, 32'h4);
    expect_irq("clr0_irq", 1'b1);
`else
    expect_reg("clr0_ecap", ADDR_EDGECAP, 32'h0);
    expect_irq("clr0_irq", 1'b0);
`endif
    bus_write(ADDR_EDGECAP, 32'hF);
    expect_reg("clrF_ecap", ADDR_EDGECAP, 32'h0);
    in_port = 4'hF;
    idle(8);
    expect_reg("rise_ignored", ADDR_EDGECAP, 32'h0);
    expect_reg("rise_data", ADDR_DATA, 32'hF);

    // 5. Key 3 falling edge detected in the same cycle as a clear-all write
    in_port = 4'h7;
    idle(DB + 2);
    expect_reg("race_data", ADDR_DATA, 32'h7);
    expect_reg("race_pre_ecap", ADDR_EDGECAP, 32'h0);
    bus_write(ADDR_EDGECAP, 32'hF);
    expect_reg("race_set_wins", ADDR_EDGECAP, 32'h8);
    expect_irq("race_irq", 1'b0);
    in_port = 4'hF;
    idle(8);
    bus_write(ADDR_EDGECAP, 32'hF);
    expect_reg("race_cleared", ADDR_EDGECAP, 32'h0);

    // 6. Reset two cycles into a debounce, then a fresh full debounce
    in_port = 4'hE;
    idle(2);
    reset_n = 1'b0;
    @(negedge clk);
    expect_reg("midrst_data", ADDR_DATA, 32'hF);
    expect_reg("midrst_mask", ADDR_IRQMASK, 32'h0);
    reset_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      expect_reg("redo_data", ADDR_DATA, (e >= DB + 1) ? 32'hE : 32'hF);
      expect_reg("redo_ecap", ADDR_EDGECAP, (e >= DB + 2) ? 32'h1 : 32'h0);
      expect_irq("redo_irq", 1'b0);
    end

    if (exp_q.size() != 0) check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
